// File: rtl/game_pkg.sv
// Shared types and constants for the Minesweeper timer / mines-left source.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DISP_MAX = 9999;
    localparam int unsigned CNT_W    = 14;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle terminal-count strobe per second.
module tick_prescaler #(
    parameter int unsigned TICKS_PER_SEC = 100000000
) (
    input  logic clock_100Mhz,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic terminal
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] count;

    assign terminal = enable && (count == LAST);

    always_ff @(posedge clock_100Mhz) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= terminal ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/game_counter_source.sv
// Game FSM, elapsed-seconds timer, mines-left counter and display mux feeding
// the seven-segment controller.
module game_counter_source
    import game_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 100000000,
    parameter int unsigned MAX_SECONDS   = 9999,
    parameter int unsigned NUM_MINES     = 10
) (
    input  logic        clock_100Mhz,
    input  logic        reset,
    input  logic        game_start,
    input  logic        game_over,
    input  logic        pause,
    input  logic        flag_place,
    input  logic        flag_remove,
    input  logic        show_mines,
    output logic [15:0] displayed_number,
    output logic        sec_tick,
    output logic        running
);

    localparam logic [CNT_W-1:0] SEC_MAX    = CNT_W'(MAX_SECONDS);
    localparam logic [CNT_W-1:0] MINES_INIT = CNT_W'(NUM_MINES);

    state_t           state, state_next;
    logic [CNT_W-1:0] seconds, seconds_next;
    logic [CNT_W-1:0] mines_left, mines_next;
    logic             presc_en, presc_clr, presc_tc;

    // Prescaler controls are derived straight from inputs so its strobe can
    // feed the next-state logic without a combinational loop.
    assign presc_en  = (state == RUN) && !game_over && !game_start && !pause;
    assign presc_clr = game_start && !((state == RUN) && game_over);

    tick_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clock_100Mhz(clock_100Mhz),
        .reset       (reset),
        .enable      (presc_en),
        .clear       (presc_clr),
        .terminal    (presc_tc)
    );

    always_comb begin
        state_next   = state;
        seconds_next = seconds;
        mines_next   = mines_left;
        case (state)
            IDLE, DONE: begin
                if (game_start) begin
                    state_next   = RUN;
                    seconds_next = '0;
                    mines_next   = MINES_INIT;
                end
            end
            RUN: begin
                if (game_over) begin
                    state_next = DONE;
                end else if (game_start) begin
                    seconds_next = '0;
                    mines_next   = MINES_INIT;
                end else begin
                    if (presc_tc && (seconds < SEC_MAX))
                        seconds_next = seconds + 1'b1;
                    if (flag_place && !flag_remove && (mines_left != '0))
                        mines_next = mines_left - 1'b1;
                    else if (flag_remove && !flag_place && (mines_left < MINES_INIT))
                        mines_next = mines_left + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_100Mhz) begin
        if (!reset) begin
            state            <= IDLE;
            seconds          <= '0;
            mines_left       <= MINES_INIT;
            displayed_number <= '0;
            sec_tick         <= 1'b0;
            running          <= 1'b0;
        end else begin
            state            <= state_next;
            seconds          <= seconds_next;
            mines_left       <= mines_next;
            displayed_number <= {2'b00, (show_mines ? mines_left : seconds)};
            sec_tick         <= presc_tc;
            running          <= (state_next == RUN);
        end
    end

endmodule

// File: tb/tb_game_counter_source.sv
// Randomized and directed bench for game_counter_source against a cycle-count model.
module tb_game_counter_source;

    localparam int unsigned TPS  = 4;
    localparam int unsigned MAXS = 9999;
    localparam int          NM   = 10;

    logic        clk = 1'b0;
    logic        rst_n, gs, go, pz, fp, fr, sm;
    logic [15:0] disp;
    logic        tick, running;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // model: elapsed active cycles since the last clear; seconds derive from it
    int unsigned m_active = 0;
    int          m_mines  = NM;
    bit          m_run    = 1'b0;
    logic [15:0] e_disp   = '0;
    bit          e_tick   = 1'b0;
    bit          e_run    = 1'b0;
    bit          cmp_en   = 1'b0;

    game_counter_source #(
        .TICKS_PER_SEC(TPS),
        .MAX_SECONDS  (MAXS),
        .NUM_MINES    (NM)
    ) dut (
        .clock_100Mhz    (clk),
        .reset           (rst_n),
        .game_start      (gs),
        .game_over       (go),
        .pause           (pz),
        .flag_place      (fp),
        .flag_remove     (fr),
        .show_mines      (sm),
        .displayed_number(disp),
        .sec_tick        (tick),
        .running         (running)
    );

    always #5 clk = ~clk;

    function automatic int unsigned m_secs();
        int unsigned s;
        s = m_active / TPS;
        return (s > MAXS) ? MAXS : s;
    endfunction

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_disp", disp, e_disp);
            check("model_tick", {15'd0, tick}, {15'd0, e_tick});
            check("model_running", {15'd0, running}, {15'd0, e_run});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_active = 0;
            m_mines  = NM;
            m_run    = 1'b0;
            e_tick   = 1'b0;
            e_disp   = '0;
        end else begin
            e_disp = sm ? 16'(m_mines) : 16'(m_secs());
            e_tick = 1'b0;
            if (m_run) begin
                if (go) begin
                    m_run = 1'b0;
                end else if (gs) begin
                    m_active = 0;
                    m_mines  = NM;
                end else begin
                    if (!pz) begin
                        m_active++;
                        e_tick = (m_active % TPS) == 0;
                    end
                    if (fp && !fr) m_mines = (m_mines > 0) ? m_mines - 1 : 0;
                    else if (fr && !fp) m_mines = (m_mines < NM) ? m_mines + 1 : NM;
                end
            end else if (gs) begin
                m_run    = 1'b1;
                m_active = 0;
                m_mines  = NM;
            end
        end
        e_run = m_run;
        rst_n = 1'b1;
        gs = 1'b0; go = 1'b0; fp = 1'b0; fr = 1'b0;
    endtask

    task automatic run_to(input int unsigned target, input int unsigned budget);
        for (int unsigned i = 0; i < budget && m_secs() != target; i++) cyc();
        cyc();
        check("reach_secs", disp, 16'(target));
    endtask

    int unsigned tcnt;

    initial begin
        rst_n = 1'b0; gs = 0; go = 0; pz = 0; fp = 0; fr = 0; sm = 0;
        // 1. reset and start
        cyc();
        cmp_en = 1'b1;
        rst_n = 1'b0; cyc();
        check("reset_disp", disp, 16'd0);
        check("reset_running", {15'd0, running}, 16'd0);
        check("reset_tick", {15'd0, tick}, 16'd0);
        cyc();
        gs = 1; cyc();
        check("start_running", {15'd0, running}, 16'd1);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            check("tick_period", {15'd0, tick}, (k % 4 == 0) ? 16'd1 : 16'd0);
            if (k % 4 == 1 && k > 1) check("disp_after_tick", disp, 16'((k - 1) / 4));
        end
        cyc();
        check("disp_after_tick", disp, 16'd3);

        // 2. pause and freeze
        run_to(5, 100);
        pz = 1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            check("pause_tick", {15'd0, tick}, 16'd0);
        end
        check("pause_disp", disp, 16'd5);
        pz = 0;
        cyc(); cyc(); cyc();
        go = 1; cyc();
        check("over_running", {15'd0, running}, 16'd0);
        repeat (40) cyc();
        check("frozen_disp", disp, 16'(m_secs()));

        // 3. flags
        gs = 1; cyc();
        sm = 1; pz = 1;
        for (int i = 1; i <= 12; i++) begin
            fp = 1; cyc();
            check("place_disp", disp, 16'((11 - i > 0) ? 11 - i : 0));
        end
        for (int j = 1; j <= 11; j++) begin
            fr = 1; cyc();
            check("remove_disp", disp, 16'((j - 1 < 10) ? j - 1 : 10));
        end
        cyc();
        check("remove_sat", disp, 16'd10);
        fp = 1; fr = 1; cyc();
        cyc();
        check("both_flags", disp, 16'd10);
        pz = 0; sm = 0;

        // 4. simultaneous events
        go = 1; gs = 1; cyc();
        check("go_gs_running", {15'd0, running}, 16'd0);
        cyc();
        check("go_gs_secs", disp, 16'(m_secs()));
        gs = 1; cyc();
        for (int i = 0; i < 7; i++) begin fp = 1; cyc(); end
        run_to(7, 100);
        go = 1; cyc();
        cyc();
        check("done_secs", disp, 16'd7);
        sm = 1; cyc();
        check("done_mines", disp, 16'd3);
        sm = 0; gs = 1; cyc();
        check("restart_running", {15'd0, running}, 16'd1);
        cyc();
        check("restart_secs", disp, 16'd0);
        sm = 1; cyc();
        check("restart_mines", disp, 16'd10);
        sm = 0;

        // 5. saturation
        run_to(9998, 50000);
        run_to(MAXS, 20);
        tcnt = 0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            if (tick) tcnt++;
        end
        check("sat_disp", disp, 16'd9999);
        check("sat_ticks", 16'(tcnt), 16'd3);

        // 6. reset priority
        gs = 1; cyc();
        run_to(12, 100);
        rst_n = 0; gs = 1; cyc();
        check("rst_running", {15'd0, running}, 16'd0);
        check("rst_disp", disp, 16'd0);
        check("rst_tick", {15'd0, tick}, 16'd0);

        // randomized traffic
        for (int k = 0; k < 5000; k++) begin
            gs = ($urandom_range(0, m_run ? 60 : 8) == 0);
            go = ($urandom_range(0, 50) == 0);
            fp = ($urandom_range(0, 3) == 0);
            fr = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) pz = ~pz;
            if ($urandom_range(0, 15) == 0) sm = ~sm;
            rst_n = ($urandom_range(0, 700) != 0);
            cyc();
        end

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
